// File: rtl/mem_responder.sv
// Single-port SRAM responder for core fetch/load/store requests.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to reject non-word-aligned addresses.
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_en,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic        fetch_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        sram_cs,
  output logic        sram_we,
  output logic [29:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic [31:0] instr,
  output logic [31:0] load_data,
  output logic        EOC,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic        fetch_q;
  logic        rd_q;
  logic        cs_q;
  logic        we_q;
  logic        eoc_q;
  logic        err_q;
  logic        busy_q;
  logic [31:0] instr_q;
  logic [31:0] load_q;

  logic misalign_d;
  logic reject_d;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign misalign_d = |addr[1:0];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];
  assign misalign_d = 1'b0;
`endif

  // Exactly one of read/write, and never a write on the fetch path.
  assign reject_d = (mem_read_en == mem_write_en)
                  | (fetch_en & mem_write_en)
                  | misalign_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      fetch_q <= 1'b0;
      rd_q    <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      eoc_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      instr_q <= '0;
      load_q  <= '0;
    end else begin
      cs_q  <= 1'b0;
      we_q  <= 1'b0;
      eoc_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (mem_en) begin
            addr_q  <= addr[31:2];
            wdata_q <= wdata;
            fetch_q <= fetch_en;
            rd_q    <= mem_read_en;
            busy_q  <= 1'b1;
            if (reject_d) begin
              state_q <= S_DONE;
              rd_q    <= 1'b0;
              eoc_q   <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_ACCESS;
              cs_q    <= 1'b1;
              we_q    <= mem_write_en;
            end
          end
        end
        S_ACCESS: begin
          if (WAIT_CYCLES == 0) begin
            state_q <= S_DONE;
            eoc_q   <= 1'b1;
            if (rd_q) begin
              if (fetch_q) instr_q <= sram_rdata;
              else         load_q  <= sram_rdata;
            end
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_DONE;
            eoc_q   <= 1'b1;
            if (rd_q) begin
              if (fetch_q) instr_q <= sram_rdata;
              else         load_q  <= sram_rdata;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sram_cs    = cs_q;
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign instr      = instr_q;
  assign load_data  = load_q;
  assign EOC        = eoc_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES 1, 0, 3) share stimulus
// and are checked cycle by cycle against a latency/acceptance model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_en;
  logic        mem_read_en;
  logic        mem_write_en;
  logic        fetch_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] sram_rdata;

  logic        cs_o   [3];
  logic        we_o   [3];
  logic [29:0] sa_o   [3];
  logic [31:0] swd_o  [3];
  logic [31:0] ins_o  [3];
  logic [31:0] ld_o   [3];
  logic        eoc_o  [3];
  logic        busy_o [3];
  logic        err_o  [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] instr_m;
  logic [31:0] load_m;

  always #5 clk = ~clk;

  function automatic int wc(input int g);
    return (g == 0) ? 1 : (g == 1) ? 0 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(.WAIT_CYCLES(wc(g))) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .mem_en      (mem_en),
      .mem_read_en (mem_read_en),
      .mem_write_en(mem_write_en),
      .fetch_en    (fetch_en),
      .addr        (addr),
      .wdata       (wdata),
      .sram_cs     (cs_o[g]),
      .sram_we     (we_o[g]),
      .sram_addr   (sa_o[g]),
      .sram_wdata  (swd_o[g]),
      .sram_rdata  (sram_rdata),
      .instr       (ins_o[g]),
      .load_data   (ld_o[g]),
      .EOC         (eoc_o[g]),
      .busy        (busy_o[g]),
      .err         (err_o[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s instr w%0d", tag, wc(g)), ins_o[g], instr_m);
      chk($sformatf("%s load w%0d", tag, wc(g)), ld_o[g], load_m);
    end
  endtask

  task automatic scramble();
    mem_read_en  = 1'($urandom);
    mem_write_en = 1'($urandom);
    fetch_en     = 1'($urandom);
    addr         = $urandom;
    wdata        = $urandom;
  endtask

  // Called at a negedge; issues one request and follows it to idle.
  task automatic req(input logic rd, input logic wr, input logic fe,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rdat, input logic hold);
    logic rej;
    int   hold_k;
    rej = (rd == wr) || (fe && wr);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    rej = rej || (a[1:0] != 2'b00);
`endif
    hold_k = hold ? (rej ? 1 : 2) : 0;
    mem_en       = 1'b1;
    mem_read_en  = rd;
    mem_write_en = wr;
    fetch_en     = fe;
    addr         = a;
    wdata        = wd;
    sram_rdata   = rdat;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      for (int g = 0; g < 3; g++) begin
        int ek;
        ek = rej ? 1 : 2 + wc(g);
        chk($sformatf("cs w%0d k%0d", wc(g), k), 32'(cs_o[g]),
            32'(!rej && k == 1));
        chk($sformatf("eoc w%0d k%0d", wc(g), k), 32'(eoc_o[g]),
            32'(k == ek));
        chk($sformatf("err w%0d k%0d", wc(g), k), 32'(err_o[g]),
            32'(rej && k == ek));
        chk($sformatf("busy w%0d k%0d", wc(g), k), 32'(busy_o[g]),
            32'(k <= ek));
        if (!rej && k == 1) begin
          chk($sformatf("we w%0d", wc(g)), 32'(we_o[g]), 32'(wr));
          chk($sformatf("saddr w%0d", wc(g)), 32'(sa_o[g]), a >> 2);
          if (wr) chk($sformatf("swdata w%0d", wc(g)), swd_o[g], wd);
        end
      end
      if (k > hold_k) mem_en = 1'b0;
      scramble();
      if (k < 6) @(negedge clk);
    end
    mem_en = 1'b0;
    if (!rej && rd) begin
      if (fe) instr_m = rdat;
      else    load_m  = rdat;
    end
    chk_regs("post");
  endtask

  initial begin
    rst_n        = 1'b0;
    mem_en       = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    fetch_en     = 1'b0;
    addr         = '0;
    wdata        = '0;
    sram_rdata   = '0;
    instr_m      = '0;
    load_m       = '0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst cs", 32'(cs_o[g]), 32'd0);
      chk("rst we", 32'(we_o[g]), 32'd0);
      chk("rst eoc", 32'(eoc_o[g]), 32'd0);
      chk("rst err", 32'(err_o[g]), 32'd0);
      chk("rst busy", 32'(busy_o[g]), 32'd0);
      chk("rst saddr", 32'(sa_o[g]), 32'd0);
    end
    chk_regs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    req(1, 0, 1, 32'h100, 32'h0, 32'h00500093, 0);
    req(0, 1, 0, 32'h200, 32'hDEADBEEF, 32'h11111111, 0);
    req(1, 1, 0, 32'h300, 32'h5, 32'h22222222, 0);
    req(1, 0, 0, 32'h40, 32'h0, 32'h12345678, 0);
    req(0, 0, 0, 32'h44, 32'h0, 32'h33333333, 1);
    req(0, 1, 1, 32'h48, 32'h6, 32'h44444444, 0);
    req(1, 0, 0, 32'h103, 32'h0, 32'hCAFEF00D, 0);
    req(1, 0, 1, 32'h104, 32'h0, 32'h00A00113, 1);

    // Reset pulse while the slow instances sit in WAIT.
    mem_en      = 1'b1;
    mem_read_en = 1'b1;
    mem_write_en = 1'b0;
    fetch_en    = 1'b1;
    addr        = 32'h180;
    sram_rdata  = 32'hBADBAD00;
    @(posedge clk);
    @(negedge clk);
    mem_en = 1'b0;
    @(negedge clk);
    chk("pre-rst busy w1", 32'(busy_o[0]), 32'd1);
    chk("pre-rst busy w3", 32'(busy_o[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    instr_m = '0;
    load_m  = '0;
    for (int g = 0; g < 3; g++) begin
      chk("mid-rst busy", 32'(busy_o[g]), 32'd0);
      chk("mid-rst cs", 32'(cs_o[g]), 32'd0);
      chk("mid-rst eoc", 32'(eoc_o[g]), 32'd0);
    end
    chk_regs("mid-rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        chk("post-rst eoc", 32'(eoc_o[g]), 32'd0);
        chk("post-rst busy", 32'(busy_o[g]), 32'd0);
      end
    end
    req(1, 0, 1, 32'h100, 32'h0, 32'h00500093, 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int kind;
      kind = int'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      unique case (kind)
        0, 1: req(1, 0, 1, a, $urandom, $urandom, 1'($urandom));
        2, 3: req(1, 0, 0, a, $urandom, $urandom, 1'($urandom));
        4, 5: req(0, 1, 0, a, $urandom, $urandom, 1'($urandom));
        default: req(1'($urandom), 1'($urandom), 1'($urandom), a,
                     $urandom, $urandom, 1'($urandom));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, extra SRAM wait cycles per access (0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_en  input  1  request strobe from core control FSM.
REQ-005 mem_read_en  input  1  read request qualifier.
REQ-006 mem_write_en  input  1  write request qualifier.
REQ-007 fetch_en  input  1  1 = instruction fetch, 0 = data access; sampled with mem_en.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data.
REQ-010 sram_cs / sram_we  output  1 each  SRAM chip select / write enable.
REQ-011 sram_addr  output  30  word address (addr[31:2]).
REQ-012 sram_wdata  output  32  write data to SRAM.
REQ-013 sram_rdata  input  32  SRAM read data, valid the cycle after sram_cs with sram_we=0.
REQ-014 instr  output  32  last fetched instruction, registered.
REQ-015 load_data  output  32  last data-load result, registered.
REQ-016 EOC  output  1  end-of-cycle pulse, one cycle per completed or rejected request.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 err  output  1  one-cycle pulse coincident with EOC on a rejected request.

Function
REQ-019 States: IDLE, ACCESS, WAIT, DONE; the FSM SHALL occupy exactly one state per cycle.
REQ-020 IDLE: on mem_en=1, latch addr, wdata, fetch_en, mem_read_en and mem_write_en, then go to ACCESS; otherwise stay in IDLE.
REQ-021 Inputs SHALL be ignored outside IDLE; mem_en held high across DONE SHALL NOT start a new request until the FSM is back in IDLE.
REQ-022 ACCESS: one cycle; sram_cs=1, sram_we=latched write, sram_addr and sram_wdata from the latched request; next state is WAIT if WAIT_CYCLES>0, else DONE.
REQ-023 WAIT: the 4-bit counter loads WAIT_CYCLES on entry and decrements each cycle; the FSM goes to DONE when the counter reaches 1; sram_cs=0.
REQ-024 On the edge entering DONE for a read, sram_rdata SHALL be captured into instr if fetch was latched, else into load_data; the other register SHALL hold its value.
REQ-025 DONE: EOC=1 for exactly one cycle; next state is always IDLE.
REQ-026 Latency: mem_en sampled at edge T gives EOC high in cycle T+2+WAIT_CYCLES; back-to-back requests SHALL be spaced at least 3+WAIT_CYCLES cycles apart.
REQ-027 A request with mem_read_en=1 and mem_write_en=1, or with both 0, SHALL be rejected: no sram_cs, FSM goes IDLE→DONE directly, EOC=1 and err=1.
REQ-028 fetch_en=1 with mem_write_en=1 SHALL be rejected as in REQ-027.
REQ-029 instr and load_data SHALL never change on a write or a rejected request.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, sram_cs=0, sram_we=0, EOC=0, err=0, busy=0, instr=0, load_data=0, counter=0, and clear the latched request.
REQ-031 Reset asserted mid-access SHALL abort the access with no EOC; the first request after reset release SHALL behave as from power-up.

Configuration
REQ-032 Macro MEM_RESPONDER_ALIGN_CHECK_EN: when defined, a request with addr[1:0]!=0 SHALL be rejected as in REQ-027 (no SRAM access, EOC+err). When undefined, addr[1:0] SHALL be ignored and the access SHALL proceed on addr[31:2].

Verification
REQ-033 WAIT_CYCLES=1, fetch read of addr 0x100 with sram_rdata=0x00500093 → EOC in cycle T+3, instr=0x00500093, load_data unchanged, err=0.
REQ-034 Store of wdata 0xDEADBEEF to addr 0x200 → one cycle with sram_cs=1, sram_we=1, sram_addr=0x80, sram_wdata=0xDEADBEEF; EOC at T+3; instr and load_data unchanged.
REQ-035 mem_read_en=1 and mem_write_en=1 together → no sram_cs, EOC=1 and err=1 in cycle T+1.
REQ-036 WAIT_CYCLES=0, data load from 0x40 returning 0x12345678 → EOC at T+2, load_data=0x12345678.
REQ-037 rst_n pulsed low during WAIT → busy and sram_cs drop immediately, no EOC; the next fetch completes normally.
REQ-038 With MEM_RESPONDER_ALIGN_CHECK_EN defined, load at 0x103 → err=1 and EOC=1, no sram_cs; without the macro, the same load SHALL access word 0x40.
